// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
// rr_next() walks at most RR_MAX_REQ positions, so requester counts up to 16
// are supported by the helper.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int RR_MAX_REQ = 16;
  localparam int RR_IDX_W   = 4;

  typedef logic [RR_MAX_REQ-1:0] rr_vec_t;
  typedef logic [RR_IDX_W-1:0]   rr_idx_t;

  // First set bit of valid_vec strictly after 'last', wrapping from max_idx
  // back to 0 explicitly so non power-of-two requester counts work. Returns
  // 'last' when nothing is valid (the caller qualifies with any_req).
  function automatic rr_idx_t rr_next(input rr_idx_t last,
                                      input rr_vec_t valid_vec,
                                      input rr_idx_t max_idx);
    rr_idx_t idx;
    rr_idx_t result;
    logic    found;
    idx    = last;
    result = last;
    found  = 1'b0;
    for (int off = 0; off < RR_MAX_REQ; off++) begin
      if (off <= int'(max_idx)) begin
        idx = (idx == max_idx) ? rr_idx_t'(0) : rr_idx_t'(idx + 1'b1);
        if (!found && valid_vec[idx]) begin
          result = idx;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: given the request vector and the
// index served last, returns the next index to serve and whether any request
// is pending. Kept standalone so a read-side scheduler can reuse it.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_idx,
  output logic [ID_WIDTH-1:0] grant,
  output logic                any_req
);

  rr_vec_t req_ext;
  rr_idx_t next_idx;

  // Zero-pad the request vector up to the width the search helper expects.
  generate
    for (genvar gi = 0; gi < RR_MAX_REQ; gi++) begin : g_req_ext
      if (gi < NUM_REQ) begin : g_used
        assign req_ext[gi] = req[gi];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Rotating priority search starting just after the last served index.
  always_comb begin
    next_idx = rr_next(rr_idx_t'(last_idx), req_ext, rr_idx_t'(NUM_REQ - 1));
  end

  assign grant   = ID_WIDTH'(next_idx);
  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the write port of a first-word-fall-through FIFO among NUM_REQ
// valid/ready producers. Grants rotate round-robin; each grant lasts up to
// MAX_BURST beats or until the granted producer drops valid. Every grant is
// preceded by a one-cycle arbitration bubble in IDLE.
// Optional build macro FIFO_WR_ARB_TAG_EN: prefixes each written word with
// the source index so the consumer can tell producers apart.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
`ifdef FIFO_WR_ARB_TAG_EN
  parameter int OUT_WIDTH  = DATA_WIDTH + ID_WIDTH
`else
  parameter int OUT_WIDTH  = DATA_WIDTH
`endif
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               fifo_wen_o,
  output logic [OUT_WIDTH-1:0]               fifo_wdata_o,
  input  logic                               fifo_full_i,
  output logic [ID_WIDTH-1:0]                grant_id_o,
  output logic                               busy_o
);

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

  arb_state_e            state_reg, state_next;
  logic [ID_WIDTH-1:0]   grant_reg, grant_next;
  logic [ID_WIDTH-1:0]   last_grant_reg, last_grant_next;
  logic [BC_W-1:0]       beat_cnt_reg, beat_cnt_next;
  logic [ID_WIDTH-1:0]   arb_grant;
  logic                  any_req;
  logic                  sel_valid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req      (req_valid_i),
    .last_idx (last_grant_reg),
    .grant    (arb_grant),
    .any_req  (any_req)
  );

  // State, grant, rotation pointer and burst counter; reset hands requester 0
  // first priority by pointing last_grant at the highest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  // Next-state and handshake logic; the write strobe follows the granted
  // producer's valid combinationally and is blocked while the FIFO is full.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    req_ready_o     = '0;
    sel_valid       = 1'b0;
    accept          = 1'b0;
    sel_data        = '0;
    case (state_reg)
      ARB_IDLE: begin
        if (any_req) begin
          grant_next = arb_grant;
          state_next = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        sel_valid              = req_valid_i[grant_reg];
        sel_data               = req_data_i[grant_reg];
        req_ready_o[grant_reg] = !fifo_full_i;
        accept                 = sel_valid && !fifo_full_i;
        // A stalled beat keeps the grant; only a dropped valid or the final
        // beat of the burst hands the port back.
        if (!sel_valid || (accept && beat_cnt_reg == LAST_BEAT)) begin
          state_next      = ARB_IDLE;
          last_grant_next = grant_reg;
          beat_cnt_next   = '0;
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + BC_W'(1);
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign fifo_wen_o = accept;
  assign busy_o     = (state_reg == ARB_GRANT);
  assign grant_id_o = grant_reg;

`ifdef FIFO_WR_ARB_TAG_EN
  assign fifo_wdata_o = busy_o ? {grant_reg, sel_data} : '0;
`else
  assign fifo_wdata_o = sel_data;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: randomized producers feed per-source
// expected queues; a monitor keeps a rule-level model of grant rotation and
// burst release, and compares every FIFO write against the queues.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_WIDTH   = 2;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OUT_WIDTH  = DATA_WIDTH + ID_WIDTH;
`else
  localparam int OUT_WIDTH  = DATA_WIDTH;
`endif

  logic                               clk = 1'b0;
  logic                               rst = 1'b1;
  logic [NUM_REQ-1:0]                 req_valid_i = '0;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic                               fifo_wen_o;
  logic [OUT_WIDTH-1:0]               fifo_wdata_o;
  logic                               fifo_full_i = 1'b0;
  logic [ID_WIDTH-1:0]                grant_id_o;
  logic                               busy_o;

  fifo_wr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .ID_WIDTH   (ID_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .fifo_wen_o   (fifo_wen_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_full_i  (fifo_full_i),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // stimulus knobs
  int vprob [NUM_REQ];
  bit gen_en[NUM_REQ];
  int drop_pct   = 0;
  int full_pct   = 0;
  bit force_full = 1'b0;

  logic [DATA_WIDTH-1:0] pend [NUM_REQ][$];
  logic [DATA_WIDTH-1:0] exp_q[NUM_REQ][$];
  logic [NUM_REQ-1:0]    acc_vec = '0;

  // observed bursts (grant, beats) recorded by the model on release
  int burst_g[$];
  int burst_n[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got none expected event at %0t", name, $time);
  endtask

  // next requester after 'last' that is valid, by modulo rotation
  function automatic int tb_rr(input int last, input logic [NUM_REQ-1:0] v);
    logic [ID_WIDTH-1:0] ix;
    for (int i = 1; i <= NUM_REQ; i++) begin
      ix = ID_WIDTH'((last + i) % NUM_REQ);
      if (v[ix]) return int'(ix);
    end
    return -1;
  endfunction

  // ---------------- producers ----------------
  initial begin
    logic [DATA_WIDTH-1:0] d;
    logic v;
    bit stalled;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc_vec[k] && pend[k].size() > 0) void'(pend[k].pop_front());
        if (gen_en[k] && pend[k].size() == 0) begin
          d = DATA_WIDTH'($urandom);
          pend[k].push_back(d);
          exp_q[k].push_back(d);
        end
        stalled = req_valid_i[k] && !acc_vec[k];
        if (vprob[k] == 0 || pend[k].size() == 0) v = 1'b0;
        else if (stalled) v = ($urandom_range(99) >= drop_pct);
        else v = ($urandom_range(99) < vprob[k]);
        req_valid_i[k] = v;
        req_data_i[k]  = v ? pend[k][0] : '0;
      end
      fifo_full_i = force_full || ($urandom_range(99) < full_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int m_last, m_beats, m_grant;
    bit exp_busy;
    logic [ID_WIDTH-1:0]   mg;
    logic [NUM_REQ-1:0]    exp_ready, prev_stall;
    logic                  exp_wen;
    logic [OUT_WIDTH-1:0]  exp_w;
    logic [DATA_WIDTH-1:0] prev_data[NUM_REQ];
    logic [DATA_WIDTH-1:0] head;
    m_last = NUM_REQ - 1; m_beats = 0; m_grant = 0; exp_busy = 1'b0;
    prev_stall = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_busy",  32'(busy_o),       32'(0));
        check("rst_wen",   32'(fifo_wen_o),   32'(0));
        check("rst_ready", 32'(req_ready_o),  32'(0));
        check("rst_grant", 32'(grant_id_o),   32'(0));
        check("rst_wdata", 32'(fifo_wdata_o), 32'(0));
        m_last = NUM_REQ - 1; m_beats = 0; exp_busy = 1'b0;
        acc_vec = '0; prev_stall = '0;
      end else begin
        for (int k = 0; k < NUM_REQ; k++)
          if (prev_stall[k] && req_valid_i[k] && req_data_i[k] !== prev_data[k])
            $error("producer %0d changed data while stalled", k);
        mg = ID_WIDTH'(m_grant);
        exp_ready = '0;
        exp_wen   = 1'b0;
        if (exp_busy && !fifo_full_i) begin
          exp_ready = NUM_REQ'(1 << m_grant);
          exp_wen   = req_valid_i[mg];
        end
        check("busy",  32'(busy_o),      32'(exp_busy));
        check("ready", 32'(req_ready_o), 32'(exp_ready));
        check("wen",   32'(fifo_wen_o),  32'(exp_wen));
        if (exp_busy) check("grant_id", 32'(grant_id_o), 32'(m_grant));
        if (exp_wen) begin
          if (exp_q[m_grant].size() == 0) begin
            report_timeout("wdata_no_expected_beat");
          end else begin
            head = exp_q[m_grant].pop_front();
`ifdef FIFO_WR_ARB_TAG_EN
            exp_w = {mg, head};
`else
            exp_w = head;
`endif
            check("wdata", 32'(fifo_wdata_o), 32'(exp_w));
          end
        end
        // rule-level model update for the next cycle
        if (exp_busy) begin
          if (!req_valid_i[mg] || (exp_wen && m_beats + 1 == MAX_BURST)) begin
            burst_g.push_back(m_grant);
            burst_n.push_back(m_beats + int'(exp_wen));
            m_last   = m_grant;
            m_beats  = 0;
            exp_busy = 1'b0;
          end else begin
            m_beats += int'(exp_wen);
          end
        end else if (|req_valid_i) begin
          exp_busy = 1'b1;
          m_grant  = tb_rr(m_last, req_valid_i);
        end
        acc_vec    = req_valid_i & req_ready_o;
        prev_stall = req_valid_i & ~req_ready_o;
        for (int k = 0; k < NUM_REQ; k++) prev_data[k] = req_data_i[k];
      end
    end
  end

  // ---------------- directed / random sequence ----------------
  task automatic set_all(input int p, input bit g);
    for (int k = 0; k < NUM_REQ; k++) begin vprob[k] = p; gen_en[k] = g; end
  endtask

  task automatic quiesce();
    int budget;
    set_all(0, 1'b0);
    force_full = 1'b0; full_pct = 0; drop_pct = 0;
    repeat (2) @(negedge clk);
    budget = 50;
    while (busy_o && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) report_timeout("quiesce");
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin pend[k].delete(); exp_q[k].delete(); end
    burst_g.delete(); burst_n.delete();
  endtask

  task automatic wait_grant(input int id);
    int budget;
    budget = 200;
    do begin @(negedge clk); #1; budget--; end
    while (!(busy_o && int'(grant_id_o) == id) && budget > 0);
    if (budget == 0) report_timeout("wait_grant");
  endtask

  task automatic wait_bursts(input int n);
    int budget;
    budget = 300;
    while (burst_g.size() < n && budget > 0) begin @(negedge clk); budget--; end
    #1;
    if (burst_g.size() < n) report_timeout("wait_bursts");
  endtask

  initial begin
    int tot;
    set_all(0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // 1: everyone requesting -> 0,1,2,3,0 with full bursts
    set_all(100, 1'b1);
    wait_bursts(5);
    for (int i = 0; i < 5 && i < burst_g.size(); i++) begin
      check("t1_grant_order", 32'(burst_g[i]), 32'(i % NUM_REQ));
      check("t1_burst_len",   32'(burst_n[i]), 32'(MAX_BURST));
    end

    // 2: only requester 2, ten beats 0xA0..0xA9 -> bursts 4,4,2
    quiesce();
    for (int i = 0; i < 10; i++) begin
      pend[2].push_back(DATA_WIDTH'(8'hA0 + i));
      exp_q[2].push_back(DATA_WIDTH'(8'hA0 + i));
    end
    vprob[2] = 100;
    wait_bursts(3);
    for (int i = 0; i < 3 && i < burst_g.size(); i++) begin
      check("t2_grant", 32'(burst_g[i]), 32'(2));
      check("t2_len",   32'(burst_n[i]), 32'((i == 2) ? 2 : 4));
    end
    check("t2_drained", 32'(exp_q[2].size()), 32'(0));

    // 3: FIFO full for 3 cycles in the middle of requester 1's burst
    quiesce();
    set_all(100, 1'b1);
    wait_grant(1);
    burst_g.delete(); burst_n.delete();
    force_full = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_hold_grant", 32'(grant_id_o),  32'(1));
      check("t3_hold_wen",   32'(fifo_wen_o),  32'(0));
      check("t3_hold_ready", 32'(req_ready_o), 32'(0));
    end
    #1 force_full = 1'b0;
    wait_bursts(1);
    if (burst_g.size() > 0) begin
      check("t3_grant", 32'(burst_g[0]), 32'(1));
      check("t3_len",   32'(burst_n[0]), 32'(MAX_BURST));
    end

    // 4: requester 3 stops after two beats; rotation wraps to 0
    quiesce();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        pend[k].push_back(DATA_WIDTH'($urandom));
        exp_q[k].push_back(pend[k][i]);
      end
      if (i < 2) begin
        pend[3].push_back(DATA_WIDTH'(8'h30 + i));
        exp_q[3].push_back(DATA_WIDTH'(8'h30 + i));
      end
    end
    vprob[3] = 100;
    wait_grant(3);
    vprob[0] = 100; vprob[1] = 100;
    wait_bursts(2);
    if (burst_g.size() >= 2) begin
      check("t4_grant3", 32'(burst_g[0]), 32'(3));
      check("t4_len3",   32'(burst_n[0]), 32'(2));
      check("t4_wrap0",  32'(burst_g[1]), 32'(0));
    end

    // 5: reset pulse in the middle of requester 2's burst
    quiesce();
    set_all(100, 1'b1);
    wait_grant(2);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    burst_g.delete(); burst_n.delete();
    wait_bursts(1);
    if (burst_g.size() > 0) check("t5_after_rst_grant", 32'(burst_g[0]), 32'(0));

    // random traffic with stalls and dropped valids
    for (int k = 0; k < NUM_REQ; k++) vprob[k] = 20 + $urandom_range(80);
    drop_pct = 10;
    full_pct = 25;
    repeat (3000) @(posedge clk);

    // drain everything still pending
    @(negedge clk);
    #1;
    set_all(100, 1'b0);
    drop_pct = 0; full_pct = 0;
    begin
      int budget;
      budget = 2000;
      do begin
        @(negedge clk);
        tot = 0;
        for (int k = 0; k < NUM_REQ; k++) tot += pend[k].size();
        budget--;
      end while ((tot != 0 || busy_o) && budget > 0);
    end
    #1;
    tot = 0;
    for (int k = 0; k < NUM_REQ; k++) tot += exp_q[k].size();
    check("drain_expected_empty", 32'(tot), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog expired");
  end

endmodule
